// File: rtl/keyboard_ctrl_axil_slave_if.sv
// rtl/keyboard_ctrl_axil_slave_if.sv - AXI4-Lite bus bundle between the VIP master and the keyboard register block
// Ports: none; the bundle carries the five AXI4-Lite channels (AW, W, B, AR, R).
// Modports: master drives addresses/data/ready-for-response, slave drives accepts/responses.
interface keyboard_ctrl_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   S_AXI_AWADDR;
  logic [2:0]          S_AXI_AWPROT;
  logic                S_AXI_AWVALID;
  logic                S_AXI_AWREADY;
  logic [DATA_W-1:0]   S_AXI_WDATA;
  logic [DATA_W/8-1:0] S_AXI_WSTRB;
  logic                S_AXI_WVALID;
  logic                S_AXI_WREADY;
  logic [1:0]          S_AXI_BRESP;
  logic                S_AXI_BVALID;
  logic                S_AXI_BREADY;
  logic [ADDR_W-1:0]   S_AXI_ARADDR;
  logic [2:0]          S_AXI_ARPROT;
  logic                S_AXI_ARVALID;
  logic                S_AXI_ARREADY;
  logic [DATA_W-1:0]   S_AXI_RDATA;
  logic [1:0]          S_AXI_RRESP;
  logic                S_AXI_RVALID;
  logic                S_AXI_RREADY;

  modport master (
    output S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    input  S_AXI_AWREADY,
    output S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    input  S_AXI_WREADY,
    input  S_AXI_BRESP, S_AXI_BVALID,
    output S_AXI_BREADY,
    output S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    input  S_AXI_ARREADY,
    input  S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    output S_AXI_RREADY
  );

  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWPROT, S_AXI_AWVALID,
    output S_AXI_AWREADY,
    input  S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WVALID,
    output S_AXI_WREADY,
    output S_AXI_BRESP, S_AXI_BVALID,
    input  S_AXI_BREADY,
    input  S_AXI_ARADDR, S_AXI_ARPROT, S_AXI_ARVALID,
    output S_AXI_ARREADY,
    output S_AXI_RDATA, S_AXI_RRESP, S_AXI_RVALID,
    input  S_AXI_RREADY
  );
endinterface

// File: rtl/keyboard_ctrl_axil_slave.sv
// rtl/keyboard_ctrl_axil_slave.sv - AXI4-Lite register block with PS/2 receiver and scan-code FIFO
// Ports:
//   ACLK, ARESETN  : clock, synchronous active-low reset
//   s_axi          : AXI4-Lite slave (CTRL 0x0, SCRATCH 0x4, DATA 0x8, STATUS 0xC)
//   ps2_clk/data   : asynchronous PS/2 keyboard lines
//   irq            : level interrupt, irq_en and FIFO non-empty
module keyboard_ctrl_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH         = 8,
  parameter int TIMEOUT_CYCLES     = 20000
) (
  input  logic                      ACLK,
  input  logic                      ARESETN,
  keyboard_ctrl_axil_slave_if.slave s_axi,
  input  logic                      ps2_clk,
  input  logic                      ps2_data,
  output logic                      irq
);

  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    RX_IDLE,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_e;

  // Bus-side state
  logic [DW-1:0] ctrl_q, ctrl_d;
  logic [DW-1:0] scratch_q, scratch_d;
  logic          awready_q, awready_d;
  logic          bvalid_q, bvalid_d;
  logic          arready_q, arready_d;
  logic          rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          ovf_q, ovf_d;
  logic          ferr_q, ferr_d;

  // Scan-code FIFO
  logic [7:0]    fifo_q [FIFO_DEPTH];
  logic [7:0]    fifo_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // PS/2 synchronisers and receiver
  logic          ps2c_meta_q, ps2c_sync_q, ps2c_prev_q;
  logic          ps2d_meta_q, ps2d_sync_q;
  rx_state_e     state_q, state_d;
  logic [7:0]    shift_q, shift_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic          parity_q, parity_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [C_S_AXI_ADDR_WIDTH-1:0] awaddr, araddr;
  logic          wr_fire, rd_fire, ps2_fall;
  logic          full, empty;
  logic [31:0]   status_w;
  logic          rx_push, rx_err, push_ok, pop;
  logic          unused_bits;

  assign awaddr   = s_axi.S_AXI_AWADDR;
  assign araddr   = s_axi.S_AXI_ARADDR;
  // The ready pulse is visible during the accept cycle; the master still holds
  // its valids, so the edge ending that cycle is where the transfer happens.
  assign wr_fire  = awready_q & s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID;
  assign rd_fire  = arready_q & s_axi.S_AXI_ARVALID;
  assign ps2_fall = ps2c_prev_q & ~ps2c_sync_q;
  assign full     = (count_q == CW'(FIFO_DEPTH));
  assign empty    = (count_q == '0);
  assign status_w = {22'b0, ferr_q, ovf_q, 2'b0, full, empty, 4'(count_q)};
  assign irq      = ctrl_q[1] & ~empty;

  assign s_axi.S_AXI_AWREADY = awready_q;
  assign s_axi.S_AXI_WREADY  = awready_q;
  assign s_axi.S_AXI_BVALID  = bvalid_q;
  assign s_axi.S_AXI_BRESP   = 2'b00;
  assign s_axi.S_AXI_ARREADY = arready_q;
  assign s_axi.S_AXI_RVALID  = rvalid_q;
  assign s_axi.S_AXI_RDATA   = rdata_q;
  assign s_axi.S_AXI_RRESP   = 2'b00;

  assign unused_bits = ^{s_axi.S_AXI_AWPROT, s_axi.S_AXI_ARPROT, awaddr, araddr};

  always_comb begin
    ctrl_d    = ctrl_q;
    scratch_d = scratch_q;
    awready_d = s_axi.S_AXI_AWVALID & s_axi.S_AXI_WVALID & ~bvalid_q & ~awready_q;
    bvalid_d  = bvalid_q;
    arready_d = s_axi.S_AXI_ARVALID & ~rvalid_q & ~arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    ovf_d     = ovf_q;
    ferr_d    = ferr_q;
    fifo_d    = fifo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    parity_d  = parity_q;
    timer_d   = timer_q;
    rx_push   = 1'b0;
    rx_err    = 1'b0;
    push_ok   = 1'b0;
    pop       = 1'b0;

    // Write channel
    if (wr_fire) begin
      bvalid_d = 1'b1;
      case (awaddr[3:2])
        2'd0: begin
          for (int b = 0; b < 4; b++) begin
            if (s_axi.S_AXI_WSTRB[b]) ctrl_d[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
          end
        end
        2'd1: begin
          for (int b = 0; b < 4; b++) begin
            if (s_axi.S_AXI_WSTRB[b]) scratch_d[8*b +: 8] = s_axi.S_AXI_WDATA[8*b +: 8];
          end
        end
        2'd3: begin
          // Only the sticky flags in byte 1 are writable, as W1C
          if (s_axi.S_AXI_WSTRB[1]) begin
            if (s_axi.S_AXI_WDATA[8]) ovf_d  = 1'b0;
            if (s_axi.S_AXI_WDATA[9]) ferr_d = 1'b0;
          end
        end
        default: ;
      endcase
    end else if (bvalid_q && s_axi.S_AXI_BREADY) begin
      bvalid_d = 1'b0;
    end

    // Read channel; a DATA read pops at the same edge RDATA is loaded
    if (rd_fire) begin
      rvalid_d = 1'b1;
      case (araddr[3:2])
        2'd0: rdata_d = ctrl_q;
        2'd1: rdata_d = scratch_q;
        2'd2: begin
          if (!empty) begin
            rdata_d = DW'({23'b0, 1'b1, fifo_q[rd_ptr_q]});
            pop     = 1'b1;
          end else begin
            rdata_d = '0;
          end
        end
        default: rdata_d = DW'(status_w);
      endcase
    end else if (rvalid_q && s_axi.S_AXI_RREADY) begin
      rvalid_d = 1'b0;
    end

    // PS/2 receiver
    if (!ctrl_q[0]) begin
      state_d = RX_IDLE;
      timer_d = '0;
    end else begin
      if (state_q != RX_IDLE) begin
        timer_d = ps2_fall ? '0 : timer_q + 1'b1;
      end
      if (ps2_fall) begin
        case (state_q)
          RX_IDLE: begin
            // A high start bit is line noise; stay put
            if (!ps2d_sync_q) begin
              state_d   = RX_DATA;
              bit_cnt_d = '0;
              timer_d   = '0;
            end
          end
          RX_DATA: begin
            shift_d   = {ps2d_sync_q, shift_q[7:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
            if (bit_cnt_q == 3'd7) state_d = RX_PARITY;
          end
          RX_PARITY: begin
            parity_d = ps2d_sync_q;
            state_d  = RX_STOP;
          end
          default: begin
            state_d = RX_IDLE;
            timer_d = '0;
            // Odd parity: data plus parity bit carry an odd number of ones
            if (ps2d_sync_q && (^{shift_q, parity_q})) rx_push = 1'b1;
            else                                       rx_err  = 1'b1;
          end
        endcase
      end else if (state_q != RX_IDLE && timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
        // Keyboard went silent mid-frame: drop the partial byte quietly
        state_d = RX_IDLE;
        timer_d = '0;
      end
    end

    // Sticky flags: setting is applied after W1C so a coincident event wins
    push_ok = rx_push & ~full;
    if (rx_push && full) ovf_d  = 1'b1;
    if (rx_err)          ferr_d = 1'b1;

    if (push_ok) begin
      fifo_d[wr_ptr_q] = shift_q;
      wr_ptr_d         = wr_ptr_q + 1'b1;
    end
    if (pop) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      ctrl_q      <= '0;
      scratch_q   <= '0;
      awready_q   <= 1'b0;
      bvalid_q    <= 1'b0;
      arready_q   <= 1'b0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      ps2c_meta_q <= 1'b0;
      ps2c_sync_q <= 1'b0;
      ps2c_prev_q <= 1'b0;
      ps2d_meta_q <= 1'b0;
      ps2d_sync_q <= 1'b0;
      state_q     <= RX_IDLE;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      parity_q    <= 1'b0;
      timer_q     <= '0;
    end else begin
      ctrl_q      <= ctrl_d;
      scratch_q   <= scratch_d;
      awready_q   <= awready_d;
      bvalid_q    <= bvalid_d;
      arready_q   <= arready_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      ps2c_meta_q <= ps2_clk;
      ps2c_sync_q <= ps2c_meta_q;
      ps2c_prev_q <= ps2c_sync_q;
      ps2d_meta_q <= ps2_data;
      ps2d_sync_q <= ps2d_meta_q;
      state_q     <= state_d;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      parity_q    <= parity_d;
      timer_q     <= timer_d;
    end
  end

endmodule

// File: tb/tb_keyboard_ctrl_axil_slave.sv
// tb/tb_keyboard_ctrl_axil_slave.sv - directed bench for the keyboard AXI4-Lite register block
module tb_keyboard_ctrl_axil_slave;
  localparam int TMO = 300;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ps2_clk = 1'b1;
  logic ps2_data = 1'b1;
  logic irq;

  always #5 clk = ~clk;

  keyboard_ctrl_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  keyboard_ctrl_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .FIFO_DEPTH(8),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ACLK(clk),
    .ARESETN(resetn),
    .s_axi(bus),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .irq(irq)
  );

  int total = 0;
  int bad = 0;
  logic [31:0] rd;
  logic [1:0] rr, br;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic [1:0] resp);
    int n;
    resp = 2'b11;
    bus.S_AXI_AWADDR = a; bus.S_AXI_WDATA = d; bus.S_AXI_WSTRB = s;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin tick(1); n++; end
    total++;
    if (bus.S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL wr_accept addr=%h awready=%b required=1", a, bus.S_AXI_AWREADY); end
    tick(1);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin tick(1); n++; end
    total++;
    if (bus.S_AXI_BVALID !== 1'b1) begin bad++; $display("FAIL wr_bvalid addr=%h bvalid=%b required=1", a, bus.S_AXI_BVALID); end
    resp = bus.S_AXI_BRESP;
    tick(1);
  endtask

  task automatic axi_read(input logic [3:0] a, output logic [31:0] d, output logic [1:0] resp);
    int n;
    d = 32'hxxxxxxxx; resp = 2'b11;
    bus.S_AXI_ARADDR = a; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin tick(1); n++; end
    total++;
    if (bus.S_AXI_ARREADY !== 1'b1) begin bad++; $display("FAIL rd_accept addr=%h arready=%b required=1", a, bus.S_AXI_ARREADY); end
    tick(1);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 50) begin tick(1); n++; end
    total++;
    if (bus.S_AXI_RVALID !== 1'b1) begin bad++; $display("FAIL rd_rvalid addr=%h rvalid=%b required=1", a, bus.S_AXI_RVALID); end
    d = bus.S_AXI_RDATA; resp = bus.S_AXI_RRESP;
    tick(1);
  endtask

  function automatic logic [10:0] ps2_frame(input logic [7:0] b, input logic par_ok, input logic stop);
    return {stop, (~^b) ^ ~par_ok, b, 1'b0};
  endfunction

  task automatic ps2_send(input logic [10:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      tick(10);
      ps2_clk = 1'b0;
      tick(10);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(10);
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    tick(3);
    total++;
    if ({bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY, bus.S_AXI_RVALID} !== 5'b0) begin
      bad++; $display("FAIL reset_handshake got=%b required=00000",
        {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_ARREADY, bus.S_AXI_RVALID});
    end
    total++;
    if (bus.S_AXI_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h required=0", bus.S_AXI_RDATA); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL reset_irq got=%b required=0", irq); end
    resetn = 1'b1;
    tick(2);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL reset_status got=%h required=00000010", rd); end
  endtask

  task automatic test_regmap();
    logic [31:0] exp_rd [4];
    exp_rd[0] = 32'h1; exp_rd[1] = 32'h2; exp_rd[2] = 32'h0; exp_rd[3] = 32'h10;
    for (int i = 0; i < 4; i++) begin
      axi_write(4'(4 * i), 32'(i + 1), 4'hF, br);
      total++;
      if (br !== 2'b00) begin bad++; $display("FAIL regmap_bresp idx=%0d got=%b required=00", i, br); end
    end
    for (int i = 0; i < 4; i++) begin
      axi_read(4'(4 * i), rd, rr);
      total++;
      if (rd !== exp_rd[i]) begin bad++; $display("FAIL regmap_read idx=%0d got=%h required=%h", i, rd, exp_rd[i]); end
      total++;
      if (rr !== 2'b00) begin bad++; $display("FAIL regmap_rresp idx=%0d got=%b required=00", i, rr); end
    end
  endtask

  task automatic test_wstrb();
    axi_write(4'h4, 32'h11223344, 4'hF, br);
    axi_write(4'h4, 32'hAABBCCDD, 4'b0010, br);
    axi_read(4'h4, rd, rr);
    total++;
    if (rd !== 32'h1122CC44) begin bad++; $display("FAIL wstrb_scratch got=%h required=1122cc44", rd); end
  endtask

  task automatic test_single_frame();
    axi_write(4'h0, 32'h3, 4'hF, br);
    ps2_send(ps2_frame(8'h1C, 1'b1, 1'b1), 11);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h1) begin bad++; $display("FAIL frame_status got=%h required=00000001", rd); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL frame_irq got=%b required=1", irq); end
    axi_read(4'h8, rd, rr);
    total++;
    if (rd !== 32'h11C) begin bad++; $display("FAIL frame_data got=%h required=0000011c", rd); end
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL frame_status_after got=%h required=00000010", rd); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL frame_irq_after got=%b required=0", irq); end
  endtask

  task automatic test_rx_disabled();
    axi_write(4'h0, 32'h2, 4'hF, br);
    ps2_send(ps2_frame(8'h44, 1'b1, 1'b1), 11);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL rxdis_status got=%h required=00000010", rd); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL rxdis_irq got=%b required=0", irq); end
    axi_write(4'h0, 32'h3, 4'hF, br);
  endtask

  task automatic test_overflow();
    for (int i = 1; i <= 9; i++) ps2_send(ps2_frame(8'(i), 1'b1, 1'b1), 11);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h128) begin bad++; $display("FAIL ovf_status got=%h required=00000128", rd); end
    total++;
    if (irq !== 1'b1) begin bad++; $display("FAIL ovf_irq got=%b required=1", irq); end
    for (int i = 1; i <= 8; i++) begin
      axi_read(4'h8, rd, rr);
      total++;
      if (rd !== 32'h100 + 32'(i)) begin bad++; $display("FAIL ovf_pop idx=%0d got=%h required=%h", i, rd, 32'h100 + 32'(i)); end
    end
    axi_read(4'h8, rd, rr);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL ovf_empty_read got=%h required=0", rd); end
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h110) begin bad++; $display("FAIL ovf_sticky got=%h required=00000110", rd); end
    axi_write(4'hC, 32'h100, 4'hF, br);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL ovf_w1c got=%h required=00000010", rd); end
  endtask

  task automatic test_frame_err();
    ps2_send(ps2_frame(8'h5A, 1'b0, 1'b1), 11);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h210) begin bad++; $display("FAIL ferr_parity got=%h required=00000210", rd); end
    axi_write(4'hC, 32'h200, 4'hF, br);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL ferr_w1c got=%h required=00000010", rd); end
    ps2_send(ps2_frame(8'h33, 1'b1, 1'b0), 11);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h210) begin bad++; $display("FAIL ferr_stop got=%h required=00000210", rd); end
    axi_write(4'hC, 32'h200, 4'hF, br);
    // start bit plus four data bits, then silence past the timeout
    ps2_send(ps2_frame(8'hA5, 1'b1, 1'b1), 5);
    tick(TMO + 50);
    ps2_send(ps2_frame(8'hF0, 1'b1, 1'b1), 11);
    axi_read(4'h8, rd, rr);
    total++;
    if (rd !== 32'h1F0) begin bad++; $display("FAIL timeout_next_frame got=%h required=000001f0", rd); end
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL timeout_status got=%h required=00000010", rd); end
  endtask

  task automatic test_bresp_hold();
    int n;
    bus.S_AXI_AWADDR = 4'h4; bus.S_AXI_WDATA = 32'hCAFE0001; bus.S_AXI_WSTRB = 4'hF;
    bus.S_AXI_AWVALID = 1'b1; bus.S_AXI_WVALID = 1'b1; bus.S_AXI_BREADY = 1'b0;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin tick(1); n++; end
    total++;
    if (bus.S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL hold_accept awready=%b required=1", bus.S_AXI_AWREADY); end
    tick(1);
    // second write presented while the first response is still pending
    bus.S_AXI_WDATA = 32'hCAFE0002;
    for (int i = 0; i < 10; i++) begin
      total++;
      if ({bus.S_AXI_BVALID, bus.S_AXI_AWREADY} !== 2'b10) begin
        bad++; $display("FAIL hold_bvalid cyc=%0d bvalid_awready=%b required=10", i, {bus.S_AXI_BVALID, bus.S_AXI_AWREADY});
      end
      tick(1);
    end
    bus.S_AXI_BREADY = 1'b1;
    tick(1);
    total++;
    if (bus.S_AXI_BVALID !== 1'b0) begin bad++; $display("FAIL hold_bvalid_clear got=%b required=0", bus.S_AXI_BVALID); end
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin tick(1); n++; end
    total++;
    if (bus.S_AXI_AWREADY !== 1'b1) begin bad++; $display("FAIL hold_second_accept awready=%b required=1", bus.S_AXI_AWREADY); end
    tick(1);
    bus.S_AXI_AWVALID = 1'b0; bus.S_AXI_WVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin tick(1); n++; end
    tick(1);
    axi_read(4'h4, rd, rr);
    total++;
    if (rd !== 32'hCAFE0002) begin bad++; $display("FAIL hold_scratch got=%h required=cafe0002", rd); end
  endtask

  task automatic test_reset_mid_read();
    int n;
    axi_write(4'h0, 32'h3, 4'hF, br);
    ps2_send(ps2_frame(8'h22, 1'b1, 1'b1), 11);
    ps2_send(ps2_frame(8'h33, 1'b1, 1'b1), 11);
    bus.S_AXI_ARADDR = 4'hC; bus.S_AXI_ARVALID = 1'b1; bus.S_AXI_RREADY = 1'b0;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin tick(1); n++; end
    tick(1);
    bus.S_AXI_ARVALID = 1'b0;
    n = 0;
    while (!bus.S_AXI_RVALID && n < 50) begin tick(1); n++; end
    tick(2);
    total++;
    if ({bus.S_AXI_RVALID, bus.S_AXI_RDATA} !== {1'b1, 32'h2}) begin
      bad++; $display("FAIL midrd_pending rvalid=%b rdata=%h required=1/00000002", bus.S_AXI_RVALID, bus.S_AXI_RDATA);
    end
    resetn = 1'b0;
    tick(1);
    total++;
    if (bus.S_AXI_RVALID !== 1'b0) begin bad++; $display("FAIL midrd_rvalid got=%b required=0", bus.S_AXI_RVALID); end
    total++;
    if (irq !== 1'b0) begin bad++; $display("FAIL midrd_irq got=%b required=0", irq); end
    resetn = 1'b1;
    tick(2);
    axi_read(4'hC, rd, rr);
    total++;
    if (rd !== 32'h10) begin bad++; $display("FAIL midrd_count got=%h required=00000010", rd); end
    axi_read(4'h0, rd, rr);
    total++;
    if (rd !== 32'h0) begin bad++; $display("FAIL midrd_ctrl got=%h required=0", rd); end
  endtask

  initial begin
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWPROT = '0; bus.S_AXI_AWVALID = 1'b0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WVALID = 1'b0;
    bus.S_AXI_BREADY = 1'b1;
    bus.S_AXI_ARADDR = '0; bus.S_AXI_ARPROT = '0; bus.S_AXI_ARVALID = 1'b0;
    bus.S_AXI_RREADY = 1'b1;
    test_reset();
    test_regmap();
    test_wstrb();
    test_single_frame();
    test_rx_disabled();
    test_overflow();
    test_frame_err();
    test_bresp_hold();
    test_reset_mid_read();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog simulation time limit reached total=%0d bad=%0d", total, bad);
    $fatal(1);
  end
endmodule

// File: doc/keyboard_ctrl_axil_slave.md
# keyboard_ctrl_axil_slave

AXI4-Lite slave register block of the keyboard controller IP, the responder side of the S00_AXI interface driven by the AXI VIP master. It exposes four 32-bit registers: control, scratch, scan-code data and status. A built-in PS/2 receiver deserialises keyboard frames into an 8-entry scan-code FIFO. Software pops the FIFO through register reads.

## Interface
- C_S_AXI_DATA_WIDTH, 32: AXI data width; only 32 is supported.
- C_S_AXI_ADDR_WIDTH, 4: AXI address width; bits [3:2] select the register.
- FIFO_DEPTH, 8: scan-code FIFO entries; must be a power of 2.
- TIMEOUT_CYCLES, 20000: ACLK cycles without a PS/2 falling edge before a partial frame is abandoned.

- ACLK, in, 1: sole clock.
- ARESETN, in, 1: reset, synchronous, active-low.
- S_AXI_AWADDR / AWPROT / AWVALID, in, 4/3/1: write address channel; AWPROT is ignored.
- S_AXI_AWREADY, out, 1: write address accept.
- S_AXI_WDATA / WSTRB / WVALID, in, 32/4/1: write data channel.
- S_AXI_WREADY, out, 1: write data accept.
- S_AXI_BRESP / BVALID, out, 2/1: write response.
- S_AXI_BREADY, in, 1: write response accept.
- S_AXI_ARADDR / ARPROT / ARVALID, in, 4/3/1: read address channel; ARPROT is ignored.
- S_AXI_ARREADY, out, 1: read address accept.
- S_AXI_RDATA / RRESP / RVALID, out, 32/2/1: read data channel.
- S_AXI_RREADY, in, 1: read data accept.
- ps2_clk, in, 1: asynchronous PS/2 clock from the keyboard.
- ps2_data, in, 1: asynchronous PS/2 data from the keyboard.
- irq, out, 1: level interrupt, high when CTRL[1]=1 and the FIFO is non-empty.

## Operation
- Register map:
  - 0x0 CTRL: R/W, all 32 bits stored. Bit0 = rx_en, bit1 = irq_en.
  - 0x4 SCRATCH: R/W, all 32 bits.
  - 0x8 DATA: read-only. Reads {23'b0, valid, scancode[7:0]}. A read while the FIFO is non-empty pops one entry. A read while empty returns 0 and does not pop.
  - 0xC STATUS:
    - [3:0] count (0..8); [4] empty; [5] full; read-only.
    - [8] overflow, sticky, write-1-to-clear.
    - [9] frame_err, sticky, write-1-to-clear.
    - All other bits read as 0.
- Writes honour WSTRB per byte. Writes to DATA and to read-only STATUS bits are ignored. Every write and read responds with OKAY (2'b00).
- PS/2 receiver:
  - ps2_clk and ps2_data pass through 2-FF synchronisers. A falling edge of the synchronised ps2_clk samples ps2_data.
  - Frame is 11 bits: start=0, 8 data bits LSB first, odd parity, stop=1.
  - Receiver FSM: IDLE (waits for start=0) → DATA (8 bits) → PARITY → STOP → IDLE.
  - A good frame pushes its byte into the FIFO.
  - Bad parity or stop=0 discards the byte and sets frame_err.
  - A start bit of 1 in IDLE is ignored.
  - No falling edge for TIMEOUT_CYCLES while outside IDLE returns the FSM to IDLE and discards the partial byte; frame_err is not set.
  - With rx_en=0 the FSM is held in IDLE and no pushes occur.
- FIFO:
  - A push while full drops the new byte, sets overflow, and leaves contents unchanged.
  - A push and a pop in the same cycle both take effect; count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH; count saturates at the range 0..8.

## Timing
- All outputs and registers reset to 0 while ARESETN=0: AWREADY, WREADY, BVALID, ARREADY, RVALID, RDATA, irq, CTRL, SCRATCH, FIFO pointers and count, sticky flags, receiver FSM (IDLE).
- Write handshake:
  - AWREADY and WREADY pulse high together for one cycle in the cycle after AWVALID, WVALID and !BVALID are all high, provided neither is already high.
  - The register update occurs at the edge ending that accept cycle.
  - BVALID rises on the next cycle and holds until BREADY is sampled high.
  - No new write is accepted while BVALID=1.
- Read handshake:
  - ARREADY pulses for one cycle when ARVALID=1 and RVALID=0.
  - RVALID and RDATA register on the next cycle and hold stable until RREADY.
  - The FIFO pop happens at the ARREADY edge, so RDATA carries the popped entry.
  - No new read is accepted while RVALID=1.
- Read and write channels operate independently. A W1C on STATUS in the same cycle as a new error event leaves the flag set: set wins.
- Receiver latency: a byte is visible in count/DATA 3 ACLK cycles after the synchronised stop-bit edge (2 sync + 1 push). irq follows count combinationally from registered state.
- ARESETN low mid-transaction aborts it. All VALID/READY outputs drop at the next edge and the FIFO is emptied.

## Test plan
- Write 0x00000001..0x00000004 to 0x0/0x4/0x8/0xC, then read all four → CTRL=0x1, SCRATCH=0x2, DATA=0x0 (empty), STATUS=0x00000010; every BRESP/RRESP = OKAY.
- WSTRB=4'b0010 writing 0xAABBCCDD to SCRATCH holding 0x11223344 → readback 0x1122CC44.
- rx_en=1, send PS/2 frame 0x1C with correct odd parity → STATUS count=1, irq=1 (irq_en=1); read DATA → 0x0000011C; STATUS then reads 0x10.
- Send 9 valid frames (0x01..0x09) without reading → count=8, full=1, overflow=1; 8 DATA reads return 0x101..0x108. Write 0x100 to STATUS → overflow clears.
- Frame 0x5A with wrong parity, then a frame with stop=0 → no push, frame_err=1; a frame truncated after 4 bits then silent for TIMEOUT_CYCLES → FSM returns to IDLE, and a following frame 0xF0 is received correctly.
- Hold BREADY=0 for 10 cycles after a write → BVALID stays 1, AWREADY stays 0 on a second write; assert ARESETN=0 mid-read → RVALID=0 next edge, count=0.
